// File: rtl/multdiv_unit.sv
// multdiv_unit: multicycle signed 32-bit Booth multiplier / non-restoring divider
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;
    logic [1:0] state;
    logic [4:0] cnt;
    logic [WIDTH:0] acc, nacc, sum, shl, div_r;
    logic [WIDTH-1:0] mq, nmq, mc, mag_a, mag_b, quo;
    logic q1, neg, dz;
    // acc/mq/mc are shared: Booth {acc,mq,q1} with multiplicand mc, or remainder/quotient/divisor magnitude
    always_comb begin
        mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        sum   = ({mq[0], q1} == 2'b01) ? acc + {mc[WIDTH-1], mc} :
                ({mq[0], q1} == 2'b10) ? acc - {mc[WIDTH-1], mc} : acc;
        shl   = {acc[WIDTH-1:0], mq[WIDTH-1]};
        div_r = acc[WIDTH] ? shl + {1'b0, mc} : shl - {1'b0, mc};
        nacc  = (state == MUL) ? {sum[WIDTH], sum[WIDTH:1]} : div_r;
        nmq   = (state == MUL) ? {sum[0], mq[WIDTH-1:1]} : {mq[WIDTH-2:0], ~div_r[WIDTH]};
        quo   = neg ? -nmq : nmq;
    end
    // start/abort, one iteration per edge, result capture on the last step, one-cycle DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mq             <= '0;
            mc             <= '0;
            q1             <= 1'b0;
            neg            <= 1'b0;
            dz             <= 1'b0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT ^ ctrl_DIV) begin
            state          <= ctrl_MULT ? MUL : DIV;
            cnt            <= '0;
            acc            <= '0;
            mq             <= ctrl_MULT ? data_operandB : mag_a;
            mc             <= ctrl_MULT ? data_operandA : mag_b;
            q1             <= 1'b0;
            neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz             <= data_operandB == '0;
            busy           <= 1'b1;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (state == MUL || state == DIV) begin
            acc <= nacc;
            mq  <= nmq;
            q1  <= mq[0];
            cnt <= cnt + 5'd1;
            if (cnt == 5'(WIDTH - 1)) begin
                state          <= DONE;
                busy           <= 1'b0;
                data_resultRDY <= 1'b1;
                data_result    <= (state == MUL) ? nmq : dz ? '0 : quo;
                data_exception <= (state == MUL) ? (nacc[WIDTH-1:0] != {WIDTH{nmq[WIDTH-1]}})
                                                 : (dz | (~neg & nmq[WIDTH-1]));
            end
        end else if (state == DONE) begin
            state          <= IDLE;
            data_resultRDY <= 1'b0;
        end
    end
endmodule
